// File: rtl/dmem_slave_if.sv
// Request/response bus between the CPU data-memory port and dmem_slave.
interface dmem_slave_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wena;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wena, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wena, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_slave.sv
// Data-memory responder: one request at a time, WAIT_CYCLES+1 edges to the response, byte-lane RAM.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_slave #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic         clk,
  input logic         rst,
  dmem_slave_if.slave bus
);
  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_wena;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH];

  logic [31:0]           w_off;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_commit;
  logic                  w_is_byte;
  logic                  w_is_half;
  logic                  w_misalign;
  logic [3:0]            w_be;
  logic [31:0]           w_wlanes;
  logic [31:0]           w_rword;
  logic [31:0]           w_rdata;

  // Out-of-range addresses simply wrap onto the array.
  assign w_off     = r_addr - BASE_ADDR;
  assign w_idx     = ADDR_WIDTH'(w_off >> 2);
  assign w_is_byte = (r_size == 2'b10);
  assign w_is_half = (r_size == 2'b01);
  assign w_rword   = r_mem[w_idx];
  assign w_commit  = (r_state == ACCESS) && (r_cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_misalign = (w_is_half && r_addr[0]) ||
                      (!w_is_byte && !w_is_half && (r_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = r_wdata;
    w_rdata  = w_rword;
    if (w_is_byte) begin
      w_be     = 4'b0001 << r_addr[1:0];
      w_wlanes = {4{r_wdata[7:0]}};
      w_rdata  = {24'd0, w_rword[{r_addr[1:0], 3'b000} +: 8]};
    end else if (w_is_half) begin
      w_be     = r_addr[1] ? 4'b1100 : 4'b0011;
      w_wlanes = {2{r_wdata[15:0]}};
      w_rdata  = {16'd0, (r_addr[1] ? w_rword[31:16] : w_rword[15:0])};
    end
    if (w_misalign) begin
      w_be = 4'b0000;
    end
    if (w_misalign || r_wena) begin
      w_rdata = 32'd0;
    end
  end

  // RAM has no reset; only the enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (w_commit && r_wena && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wlanes[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_wena      <= 1'b0;
      r_size      <= 2'b00;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_wena  <= bus.req_wena;
            r_size  <= bus.req_size;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_cnt   <= LP_WAIT;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_misalign;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: doc/dmem_slave.md
# dmem_slave

Data-memory responder for the pipelined CPU's data-memory access path. Accepts one load/store request at a time through a valid/ready handshake, models a configurable number of wait states, and performs little-endian word, halfword or byte accesses on an internal byte-lane RAM. Returns a registered, zero-extended response; sign extension stays with the requester.

## Interface
- `ADDR_WIDTH`, default 11: number of word-index bits, giving 2^11 words (8 KiB).
- `BASE_ADDR`, default 32'h1001_0000: byte address of word 0.
- `WAIT_CYCLES`, default 1: extra access cycles per request, from 0 to 15.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request.
- `req_wena` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = word, 01 = halfword, 10 = byte, 11 = treated as word.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `rsp_valid` out 1: a response is present.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_rdata` out 32: load data, right-aligned and zero-extended; 0 for stores.
- `rsp_err` out 1: misaligned access.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- `req_ready` equals (state == IDLE), combinationally. It has no dependency on `req_valid`.
- **IDLE:** when `req_valid && req_ready`, latch wena, size, addr and wdata, load `cnt = WAIT_CYCLES`, and go to ACCESS.
- **ACCESS:** while `cnt != 0`, decrement `cnt`.
- **ACCESS, at `cnt == 0`:** perform the RAM operation, register `rsp_rdata` and `rsp_err`, set `rsp_valid`, and go to RESP.
- **RESP:** hold all response outputs stable. When `rsp_ready` is high, clear `rsp_valid` and go to IDLE.
- **Word index:** `(addr − BASE_ADDR) >> 2`, truncated to `ADDR_WIDTH` bits. Out-of-range addresses wrap modulo the array size; no error is raised.
- **Lanes:** little-endian. Byte lane k is bits [8k+7:8k] and is selected by `addr[1:0]`. A halfword uses lanes {1,0} when `addr[1]=0` and lanes {3,2} when `addr[1]=1`.
- **Store:** `req_wdata[7:0]` or `[15:0]` is replicated onto the selected lanes. Only those lanes are written and the other lanes keep their value. `rsp_rdata` = 0.
- **Load:** the selected lanes are shifted down to bit 0 and the upper bits are zero-filled.
- **Memory contents:** not reset. Initial contents are undefined (X in simulation).

## Timing
- **Reset values:** state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `cnt`=0.
- **Latency:** if the request is accepted on edge E0, the RAM operation happens on edge E0+WAIT_CYCLES+1 and `rsp_valid` is high from that same edge.
- **Throughput:** with `rsp_ready` held high, one request every WAIT_CYCLES+3 cycles.
- **Stalled consumer:** if `rsp_ready` is low, RESP holds indefinitely and `req_ready` stays 0.
- **Load after store:** a load to the same address accepted after a store's response returns the stored data. There is no overlap, so no hazard.
- **Reset mid-operation:** the pending request is dropped. A store is not committed unless the commit edge occurred before `rst` rose.
- **Idle inputs:** `req_*` inputs are ignored outside IDLE.
- **Response during acceptance:** `rsp_rdata` and `rsp_err` keep the previous response's value until the next commit edge.

## Configuration
- **`DMEM_ALIGN_CHECK_EN` defined:**
  - a halfword with `addr[0]=1`, or a word with `addr[1:0]≠0`, sets `rsp_err`=1;
  - for such a store, no lane is written;
  - for such a load, `rsp_rdata`=0;
  - the latency is unchanged.
- **`DMEM_ALIGN_CHECK_EN` not defined:**
  - `rsp_err` is tied to 0;
  - words ignore `addr[1:0]` and halfwords ignore `addr[0]` (forced alignment);
  - the access proceeds normally.

## Test plan
- **Word store then load:** with WAIT_CYCLES=1, reset, store word 0xDEADBEEF to 0x10010004, then load a word from 0x10010004. Required: `rsp_valid` 2 cycles after each accept, and the load returns 0xDEADBEEF with `rsp_err`=0.
- **Byte store and lane loads:** store byte 0xA5 to 0x10010007, then load a word from 0x10010004 and a byte from 0x10010007. Required: the word is 0xA5ADBEEF and the byte is 0x000000A5.
- **Halfword lanes:** store half 0x1234 to 0x10010002 over a word of 0, then load a word. Required: 0x12340000. A halfword load from 0x10010002 returns 0x00001234.
- **Response backpressure:** hold `rsp_ready`=0 for 5 cycles during RESP. Required: `rsp_valid`/`rsp_rdata` stay stable and `req_ready` stays 0; one cycle after `rsp_ready` goes high, `req_ready`=1.
- **Misalignment:** with `DMEM_ALIGN_CHECK_EN`, store word 0xFFFFFFFF to 0x10010005. Required: `rsp_err`=1, and a later word load from 0x10010004 is unchanged (0xA5ADBEEF). Without the macro, the same store overwrites 0x10010004 with `rsp_err`=0.
- **Reset mid-store:** assert `rst` in ACCESS of a store with WAIT_CYCLES=3. Required: outputs return to reset values immediately and the targeted word is unchanged.
